memory_stage: RTL and testbench



---
 rtl/y86_pkg.sv | 38 +++
 rtl/mem_ctl_decode.sv | 64 ++++++
 rtl/memory_stage.sv | 145 ++++++++++++++
 tb/tb_memory_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the SEQ memory stage.
//   - Y86-64 instruction codes (I_*)
//   - memory-stage FSM state encoding (ms_state_t)
//   - default data-memory size and request timeout
//   - access_fits(): bounds check for an 8-byte access
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVX  = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_DONE = 2'd2
  } ms_state_t;

  localparam logic [63:0] DEFAULT_ADDR_LIMIT     = 64'h2000;
  localparam int          DEFAULT_TIMEOUT_CYCLES = 255;

  // Legal when addr + 8 <= limit. Written as addr <= limit - 8 so that an
  // address near 2^64 (where addr + 8 would wrap) is rejected rather than
  // appearing small.
  function automatic logic access_fits(input logic [63:0] addr,
                                       input logic [63:0] limit);
    return (limit >= 64'd8) && (addr <= (limit - 64'd8));
  endfunction

endpackage

// File: rtl/mem_ctl_decode.sv
// mem_ctl_decode: purely combinational decode of the data-memory access an
// instruction needs.
// Ports:
//   i_icode   instruction code
//   i_val_e   ALU result (address for rmmovq/mrmovq/call/pushq)
//   i_val_a   register A (store data, or address for ret/popq)
//   i_val_p   incremented PC (store data for call)
//   o_needs_mem  instruction accesses data memory
//   o_is_write   access is a store
//   o_addr       byte address of the access
//   o_wdata      store data (0 for reads / no access)
//   o_addr_ok    8-byte access at o_addr fits inside ADDR_LIMIT
module mem_ctl_decode
  import y86_pkg::*;
#(
  parameter logic [63:0] ADDR_LIMIT = DEFAULT_ADDR_LIMIT
) (
  input  logic [3:0]  i_icode,
  input  logic [63:0] i_val_e,
  input  logic [63:0] i_val_a,
  input  logic [63:0] i_val_p,
  output logic        o_needs_mem,
  output logic        o_is_write,
  output logic [63:0] o_addr,
  output logic [63:0] o_wdata,
  output logic        o_addr_ok
);

  // NOTE: every output gets a default before the case, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    o_needs_mem = 1'b0;
    o_is_write  = 1'b0;
    o_addr      = '0;
    o_wdata     = '0;
    unique case (i_icode)
      I_RMMOVQ, I_PUSHQ: begin
        o_needs_mem = 1'b1;
        o_is_write  = 1'b1;
        o_addr      = i_val_e;
        o_wdata     = i_val_a;
      end
      I_CALL: begin
        o_needs_mem = 1'b1;
        o_is_write  = 1'b1;
        o_addr      = i_val_e;
        o_wdata     = i_val_p;
      end
      I_MRMOVQ: begin
        o_needs_mem = 1'b1;
        o_addr      = i_val_e;
      end
      // ret and popq read from the old stack pointer, carried in valA.
      I_RET, I_POPQ: begin
        o_needs_mem = 1'b1;
        o_addr      = i_val_a;
      end
      default: ;
    endcase
  end

  assign o_addr_ok = access_fits(o_addr, ADDR_LIMIT);

endmodule

// File: rtl/memory_stage.sv
// memory_stage: SEQ memory stage. Accepts execute results on a start pulse,
// performs at most one data-memory access over a req/ack port, and reports
// valM and an address/bus/timeout error with a one-cycle done pulse.
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   start, icode, valE, valA, valP  execute-stage results (sampled in IDLE)
//   mem_req/we/addr/wdata           request side of the data-memory port
//   mem_ack/rdata/err               response side of the data-memory port
//   busy                            access in flight
//   done                            one-cycle pulse: valM, dmem_error valid
//   valM, dmem_error                result, held until the next done
module memory_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] ADDR_LIMIT     = DEFAULT_ADDR_LIMIT,
  parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic        dmem_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

  ms_state_t        r_state;
  ms_state_t        w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             w_timeout;

  logic             w_needs_mem;
  logic             w_is_write;
  logic [63:0]      w_addr;
  logic [63:0]      w_wdata;
  logic             w_addr_ok;
  logic             w_issue;

  mem_ctl_decode #(
    .ADDR_LIMIT (ADDR_LIMIT)
  ) u_decode (
    .i_icode     (icode),
    .i_val_e     (valE),
    .i_val_a     (valA),
    .i_val_p     (valP),
    .o_needs_mem (w_needs_mem),
    .o_is_write  (w_is_write),
    .o_addr      (w_addr),
    .o_wdata     (w_wdata),
    .o_addr_ok   (w_addr_ok)
  );

  assign w_issue = w_needs_mem && w_addr_ok;

  // Saturating count of REQ cycles seen without ack; the abort fires on the
  // cycle that would bring it to TIMEOUT_CYCLES, so mem_req is high for
  // exactly TIMEOUT_CYCLES cycles before giving up.
  assign w_count_next = (r_count == '1) ? r_count : r_count + CNT_W'(1);
  assign w_timeout    = (w_count_next == CNT_W'(TIMEOUT_CYCLES));

  // State register.
  // NOTE: reset is sampled on the clock edge only (synchronous); reset_n is
  // deliberately absent from the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= MS_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      MS_IDLE: if (start) w_state_next = w_issue ? MS_REQ : MS_DONE;
      MS_REQ:  if (mem_ack || w_timeout) w_state_next = MS_DONE;
      MS_DONE: w_state_next = MS_IDLE;
      default: w_state_next = MS_IDLE;
    endcase
  end

  // Outputs decoded from state. mem_req follows r_state so a reset in REQ
  // drops it on the same edge, and an ack outside REQ is never looked at.
  always_comb begin
    mem_req = (r_state == MS_REQ);
    busy    = (r_state == MS_REQ);
    done    = (r_state == MS_DONE);
  end

  // Request fields, timeout counter and result registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r_count    <= '0;
      valM       <= '0;
      dmem_error <= 1'b0;
    end else begin
      unique case (r_state)
        MS_IDLE: begin
          if (start) begin
            r_count <= '0;
            if (w_issue) begin
              // Latched once; held stable for the whole request.
              mem_we    <= w_is_write;
              mem_addr  <= w_addr;
              mem_wdata <= w_wdata;
            end else begin
              valM       <= '0;
              dmem_error <= w_needs_mem;  // needs_mem here means bad address
            end
          end
        end
        MS_REQ: begin
          if (mem_ack) begin
            valM       <= mem_we ? 64'd0 : mem_rdata;
            dmem_error <= mem_err;
          end else if (w_timeout) begin
            valM       <= '0;
            dmem_error <= 1'b1;
          end else begin
            r_count <= w_count_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        mem_err;
  logic        busy, done;
  logic [63:0] valM;
  logic        dmem_error;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .icode      (icode),
    .valE       (valE),
    .valA       (valA),
    .valP       (valP),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .busy       (busy),
    .done       (done),
    .valM       (valM),
    .dmem_error (dmem_error)
  );

  typedef struct {
    logic [63:0] val_m;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected no done (valM=0x%0h)", valM);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_valM", valM, e.val_m);
        check("sb_dmem_error", {63'd0, dmem_error}, {63'd0, e.err});
      end
    end
  end

  task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p);
    @(posedge clk); #1;
    start = 1'b1; icode = ic; valE = e; valA = a; valP = p;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Memory model: acks n cycles after the first request cycle, checking the
  // request fields every cycle the request is up.
  task automatic serve(input int n, input logic [63:0] rdata, input logic err,
                       input logic exp_we, input logic [63:0] exp_addr,
                       input logic [63:0] exp_wdata);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("req_wait", {63'd0, mem_req}, 64'd1);
      check("addr_wait", mem_addr, exp_addr);
      @(posedge clk); #1;
    end
    mem_ack = 1'b1; mem_rdata = rdata; mem_err = err;
    @(negedge clk);
    check("req_ack", {63'd0, mem_req}, 64'd1);
    check("we", {63'd0, mem_we}, {63'd0, exp_we});
    check("addr", mem_addr, exp_addr);
    if (exp_we) check("wdata", mem_wdata, exp_wdata);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
  endtask

  task automatic expect_done(input string name);
    @(negedge clk);
    check({name, "_done"}, {63'd0, done}, 64'd1);
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
    check({name, "_req"}, {63'd0, mem_req}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    bit dropped;
    reset_n = 1'b0; start = 1'b0; icode = '0; valE = '0; valA = '0; valP = '0;
    mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {63'd0, mem_req}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_valM", valM, 64'd0);
    check("rst_err", {63'd0, dmem_error}, 64'd0);
    check("rst_addr", mem_addr, 64'd0);
    reset_n = 1'b1;

    // OPq: no access, done at t+1.
    sb_q.push_back('{64'd0, 1'b0});
    issue(4'h6, 64'h1234, 64'h5678, 64'h9);
    expect_done("nop");

    // mrmovq read, ack 3 cycles after request.
    sb_q.push_back('{64'hDEADBEEF, 1'b0});
    issue(4'h5, 64'h100, 64'h777, 64'h0);
    serve(3, 64'hDEADBEEF, 1'b0, 1'b0, 64'h100, 64'h0);
    expect_done("mrmovq");

    // call write, same-cycle ack; a write returns valM=0 even if rdata is set.
    sb_q.push_back('{64'd0, 1'b0});
    issue(4'h8, 64'h1F8, 64'h77, 64'h42);
    serve(0, 64'hBAD, 1'b0, 1'b1, 64'h1F8, 64'h42);
    expect_done("call");

    // popq at the last legal 8-byte slot reads from valA.
    sb_q.push_back('{64'h1234, 1'b0});
    issue(4'hB, 64'h500, 64'h1FF8, 64'h0);
    serve(1, 64'h1234, 1'b0, 1'b0, 64'h1FF8, 64'h0);
    expect_done("pop_edge");

    // One byte past the limit: no request, immediate error.
    sb_q.push_back('{64'd0, 1'b1});
    issue(4'hB, 64'h500, 64'h1FF9, 64'h0);
    expect_done("pop_over");

    // Address whose +8 wraps.
    sb_q.push_back('{64'd0, 1'b1});
    issue(4'hB, 64'h500, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    expect_done("pop_wrap");

    // pushq never acked: request held 255 cycles, then aborted.
    sb_q.push_back('{64'd0, 1'b1});
    issue(4'hA, 64'h80, 64'h55, 64'h0);
    hi = 0; dropped = 0;
    for (int i = 0; i < 300 && !dropped; i++) begin
      @(negedge clk);
      if (mem_req) hi++;
      else dropped = 1;
    end
    check("timeout_req_cycles", hi, 255);
    check("timeout_done", {63'd0, done}, 64'd1);

    // Bus error on a read: rdata still returned, error flagged.
    sb_q.push_back('{64'hAAAA, 1'b1});
    issue(4'h5, 64'h200, 64'h0, 64'h0);
    serve(2, 64'hAAAA, 1'b1, 1'b0, 64'h200, 64'h0);
    expect_done("bus_err");

    // ret with a second start while busy, and another start in the DONE cycle.
    sb_q.push_back('{64'h9999, 1'b0});
    issue(4'h9, 64'h0, 64'h300, 64'h0);
    start = 1'b1; icode = 4'h5; valE = 64'h400;
    @(posedge clk); #1;
    start = 1'b0;
    serve(1, 64'h9999, 1'b0, 1'b0, 64'h300, 64'h0);
    expect_done("ret_busy");
    start = 1'b1; icode = 4'h6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("start_in_done_ignored", {63'd0, done}, 64'd0);

    // Reset while in REQ; a late ack must not produce done.
    issue(4'h5, 64'h100, 64'h0, 64'h0);
    @(negedge clk);
    check("pre_rst_req", {63'd0, mem_req}, 64'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_req_drop", {63'd0, mem_req}, 64'd0);
    check("rst_busy_drop", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 64'h5555;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) begin
      @(negedge clk);
      check("late_ack_no_done", {63'd0, done}, 64'd0);
    end

    check("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
